uart_tx: RTL and testbench

UART transmitter that serialises bytes onto `tx` as 8N1 frames, LSB first, at a fixed bit period set by a parameter. It is the outbound counterpart of the existing `uart` receiver and runs in the `uart_clk` domain produced by `clkgen`. A 4-entry input FIFO absorbs short bursts from the producer, so frames go out back-to-back without idle gaps.

---
 rtl/uart_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a 4-entry input FIFO so queued bytes
// leave back-to-back with no idle gap between stop bit and next start bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [7:0]  fifo_mem [0:3];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        push;
    logic        pop;
    logic [7:0]  fifo_head;

    state_t      state;
    state_t      state_next;
    logic        tx_next;
    logic [7:0]  shift;
    logic [7:0]  shift_next;
    logic [15:0] baud;
    logic [15:0] baud_next;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_next;
    logic        baud_end;

    assign ready     = (count != 3'd4);
    assign push      = data_valid && ready;
    assign fifo_head = fifo_mem[rd_ptr];
    assign baud_end  = (baud == BAUD_LAST);
    assign busy      = (state != IDLE) || (count != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push && !pop) begin
                count <= count + 3'd1;
            end else if (pop && !push) begin
                count <= count - 3'd1;
            end
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (data_valid && !ready) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            baud    <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_next;
            tx      <= tx_next;
            shift   <= shift_next;
            baud    <= baud_next;
            bit_cnt <= bit_next;
        end
    end

    // Every transition happens on a baud wrap (or from IDLE with baud at 0),
    // so the counter restarts at 0 on each state entry.
    always_comb begin
        state_next = state;
        tx_next    = tx;
        shift_next = shift;
        baud_next  = baud_end ? 16'd0 : baud + 16'd1;
        bit_next   = bit_cnt;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                tx_next   = 1'b1;
                baud_next = 16'd0;
                if (count != 3'd0) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    tx_next    = shift[0];
                    bit_next   = 3'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_cnt == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        shift_next = shift >> 1;
                        tx_next    = shift[1];
                        bit_next   = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (count != 3'd0) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a cycle-level frame-schedule model checked
// every cycle, a waveform table for one byte, and directed corner sequences.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       data_valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .data_valid (data_valid),
        .ready      (ready),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference: a queue of waiting bytes plus the edge at which the current
    // frame began; line level is derived from the offset into the frame.
    logic [7:0] m_fifo [$];
    bit         m_active = 0;
    bit         m_ovf    = 0;
    bit         m_ready;
    longint     cyc      = 0;
    longint     m_start  = 0;
    logic [7:0] m_byte   = 8'h00;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_fifo.delete();
            m_active = 0;
            m_ovf    = 0;
        end else begin
            cyc++;
            m_ready = (m_fifo.size() != 4);
            if (data_valid && !m_ready) m_ovf = 1;
            if (!m_active || (cyc - m_start) == longint'(10 * CPB)) begin
                if (m_fifo.size() != 0) begin
                    m_byte   = m_fifo.pop_front();
                    m_active = 1;
                    m_start  = cyc;
                end else begin
                    m_active = 0;
                end
            end
            if (data_valid && m_ready) m_fifo.push_back(data);
        end
    end

    function automatic logic exp_tx();
        int off;
        int slot;
        if (!m_active) return 1'b1;
        off  = int'(cyc - m_start);
        slot = off / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_byte[slot-1];
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return m_active || (m_fifo.size() != 0);
    endfunction

    function automatic logic exp_ready();
        return m_fifo.size() != 4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        @(negedge clk);
        data_valid = v;
        data       = d;
    endtask

    task automatic waitIdle(input int limit, input string name);
        int n = 0;
        while (busy && n < limit) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput(name, 32'(busy), 32'(1'b0));
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            checkOutput("model_tx",       32'(tx),       32'(exp_tx()));
            checkOutput("model_busy",     32'(busy),     32'(exp_busy()));
            checkOutput("model_ready",    32'(ready),    32'(exp_ready()));
            checkOutput("model_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // Counts start bits seen on the line, skipping the rest of each frame.
    int starts = 0;
    int skip   = 0;
    initial forever begin
        @(negedge clk or posedge rst);
        if (rst) begin
            skip = 0;
        end else if (skip > 0) begin
            skip--;
        end else if (tx == 1'b0) begin
            starts++;
            skip = 10 * CPB - 1;
        end
    end

    typedef struct {
        int   k;
        logic tx_e;
        logic busy_e;
        logic ready_e;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int idx;
        int nfall;
        int first;
        int second;
        int busy_drop;
        int s0;
        logic prev;

        // 0xA5 goes out LSB first as 1,0,1,0,0,1,0,1; k counts edges after the push.
        tbl[0]  = '{0,  1'b1, 1'b1, 1'b1};
        tbl[1]  = '{1,  1'b0, 1'b1, 1'b1};
        tbl[2]  = '{4,  1'b0, 1'b1, 1'b1};
        tbl[3]  = '{5,  1'b1, 1'b1, 1'b1};
        tbl[4]  = '{8,  1'b1, 1'b1, 1'b1};
        tbl[5]  = '{9,  1'b0, 1'b1, 1'b1};
        tbl[6]  = '{13, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{17, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{21, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{25, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{29, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{33, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{36, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{37, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{40, 1'b1, 1'b1, 1'b1};
        tbl[15] = '{41, 1'b1, 1'b0, 1'b1};

        data_valid = 1'b0;
        data       = 8'h00;
        rst        = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1;
        $display("[TB] reset values");
        checkOutput("reset_tx",       32'(tx),       32'(1'b1));
        checkOutput("reset_busy",     32'(busy),     32'(1'b0));
        checkOutput("reset_ready",    32'(ready),    32'(1'b1));
        checkOutput("reset_overflow", 32'(overflow), 32'(1'b0));

        $display("[TB] single byte 0xA5");
        applyStimulus(1'b1, 8'hA5);
        idx = 0;
        for (int k = 0; k <= 42; k++) begin
            applyStimulus(1'b0, 8'h00);
            while (idx < 16 && tbl[idx].k == k) begin
                checkOutput($sformatf("tbl_tx_k%0d", k),    32'(tx),    32'(tbl[idx].tx_e));
                checkOutput($sformatf("tbl_busy_k%0d", k),  32'(busy),  32'(tbl[idx].busy_e));
                checkOutput($sformatf("tbl_ready_k%0d", k), 32'(ready), 32'(tbl[idx].ready_e));
                idx++;
            end
        end
        waitIdle(20, "single_idle");

        $display("[TB] back-to-back 0x00 0xFF");
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        prev = 1'b1; nfall = 0; first = -1; second = -1; busy_drop = 0;
        for (int i = 0; i < 90; i++) begin
            applyStimulus(1'b0, 8'h00);
            if (i < 80 && !busy) busy_drop++;
            if (prev && !tx) begin
                if (nfall == 0) first = i;
                else if (nfall == 1) second = i;
                nfall++;
            end
            prev = tx;
        end
        checkOutput("b2b_falls",     32'(nfall),          32'(2));
        checkOutput("b2b_spacing",   32'(second - first), 32'(10 * CPB));
        checkOutput("b2b_busy_drop", 32'(busy_drop),      32'(0));
        waitIdle(20, "b2b_idle");

        $display("[TB] fifo full and overflow");
        s0 = starts;
        for (int b = 1; b <= 6; b++) applyStimulus(1'b1, 8'(b * 17));
        applyStimulus(1'b0, 8'h00);
        checkOutput("ovf_set",   32'(overflow), 32'(1'b1));
        checkOutput("ovf_ready", 32'(ready),    32'(1'b0));
        waitIdle(400, "ovf_drain");
        checkOutput("ovf_frames", 32'(starts - s0), 32'(5));
        checkOutput("ovf_sticky", 32'(overflow),     32'(1'b1));

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(1'b1, 8'h5A);
        applyStimulus(1'b1, 8'hC3);
        repeat (12) applyStimulus(1'b0, 8'h00);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_tx",       32'(tx),       32'(1'b1));
        checkOutput("arst_busy",     32'(busy),     32'(1'b0));
        checkOutput("arst_ready",    32'(ready),    32'(1'b1));
        checkOutput("arst_overflow", 32'(overflow), 32'(1'b0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) applyStimulus(1'b0, 8'h00);
        checkOutput("arst_discard", 32'(busy), 32'(1'b0));

        $display("[TB] reset pulse during DATA then 0x3C");
        applyStimulus(1'b1, 8'h77);
        repeat (10) applyStimulus(1'b0, 8'h00);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        applyStimulus(1'b1, 8'h3C);
        applyStimulus(1'b0, 8'h00);
        checkOutput("recover_tx_n",   32'(tx),   32'(1'b1));
        checkOutput("recover_busy_n", 32'(busy), 32'(1'b1));
        applyStimulus(1'b0, 8'h00);
        checkOutput("recover_tx_n1",  32'(tx),   32'(1'b0));
        waitIdle(60, "recover_idle");

        $display("[TB] push on the pop cycle");
        applyStimulus(1'b1, 8'h12);
        applyStimulus(1'b1, 8'h34);
        repeat (39) applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b1, 8'h56);
        applyStimulus(1'b1, 8'h78);
        applyStimulus(1'b1, 8'h9A);
        applyStimulus(1'b1, 8'hBC);
        applyStimulus(1'b0, 8'h00);
        checkOutput("pushpop_full",   32'(ready),    32'(1'b0));
        checkOutput("pushpop_no_ovf", 32'(overflow), 32'(1'b0));
        waitIdle(300, "pushpop_drain");

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
            applyStimulus($urandom_range(0, 99) < 3, 8'($urandom));
        end
        waitIdle(400, "random_drain");

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
